// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing constants
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DEF_CLK_DIV   = 434;
    localparam int unsigned DEF_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 and wraps; tick marks the last
// clock of each bit period. clr restarts the period from zero.
module uart_baud_gen #(
    parameter int unsigned CLK_DIV = uart_pkg::DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and shifts it out LSB
// first with start, optional parity and 1-2 stop bits, CLK_DIV clocks each.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    uart_state_e          state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 par, par_n;
    logic                 tx_n, ready_n, busy_n;
    logic                 handshake;
    logic                 tick;

    assign handshake = tx_valid && tx_ready;

    // Restarting the period on handshake makes the start bit exactly CLK_DIV long.
    uart_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (handshake),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            par      <= par_n;
            tx       <= tx_n;
            tx_ready <= ready_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        par_n     = par;
        tx_n      = 1'b1;
        ready_n   = 1'b0;
        busy_n    = 1'b1;

        case (state)
            IDLE: begin
                if (handshake) begin
                    state_n   = START;
                    shift_n   = tx_data;
                    par_n     = (^tx_data) ^ 1'(PARITY_ODD);
                    bit_idx_n = '0;
                end
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = IDLE;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                bit_idx_n = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register with it.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances at CLK_DIV=4 (8N1, even
// parity, odd parity, two stop bits) driven from a frame table plus sequences.
module tb_uart_tx;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [4];
    logic       vin [4];
    logic       txo [4];
    logic       rdy [4];
    logic       bsy [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .CLK_DIV(DIV)) dut_n1 (
        .clk(clk), .rst(rst), .tx_data(din[0]), .tx_valid(vin[0]),
        .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]));
    uart_tx #(.DATA_BITS(8), .CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk(clk), .rst(rst), .tx_data(din[1]), .tx_valid(vin[1]),
        .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]));
    uart_tx #(.DATA_BITS(8), .CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk(clk), .rst(rst), .tx_data(din[2]), .tx_valid(vin[2]),
        .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]));
    uart_tx #(.DATA_BITS(8), .CLK_DIV(DIV), .STOP_BITS(2)) dut_s2 (
        .clk(clk), .rst(rst), .tx_data(din[3]), .tx_valid(vin[3]),
        .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]));

    typedef struct {
        int unsigned sel;
        logic [7:0]  data;
        logic [11:0] levels;  // bit i = line level of bit period i
        int unsigned nlev;
        bit          pulse;   // pulse tx_valid mid-frame
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int unsigned ncyc;
        ncyc = v.nlev * DIV;
        @(negedge clk);
        check("ready_before", rdy[v.sel], 1'b1);
        din[v.sel] = v.data;
        vin[v.sel] = 1'b1;
        @(negedge clk);
        vin[v.sel] = 1'b0;
        din[v.sel] = ~v.data;
        for (int c = 0; c < int'(ncyc); c++) begin
            if (c != 0) @(negedge clk);
            check($sformatf("tx sel%0d d%02h c%0d", v.sel, v.data, c),
                  txo[v.sel], v.levels[c / DIV]);
            check("ready_low", rdy[v.sel], 1'b0);
            check("busy_high", bsy[v.sel], 1'b1);
            if (v.pulse && c == 13) begin
                din[v.sel] = 8'hC3;
                vin[v.sel] = 1'b1;
            end else if (v.pulse && c == 14) begin
                vin[v.sel] = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_tx", txo[v.sel], 1'b1);
        check("idle_ready", rdy[v.sel], 1'b1);
        check("idle_busy", bsy[v.sel], 1'b0);
    endtask

    initial begin
        logic [9:0] f1;
        logic [9:0] f2;
        logic       exp;

        vecs[0] = '{0, 8'hA5, 12'b0000_1101001010, 10, 1'b0};
        vecs[1] = '{0, 8'h00, 12'b0000_1000000000, 10, 1'b0};
        vecs[2] = '{0, 8'hFF, 12'b0000_1111111110, 10, 1'b0};
        vecs[3] = '{0, 8'h3C, 12'b0000_1001111000, 10, 1'b1};
        vecs[4] = '{1, 8'hA5, 12'b000_10101001010, 11, 1'b0};
        vecs[5] = '{1, 8'h01, 12'b000_11000000010, 11, 1'b0};
        vecs[6] = '{2, 8'hA5, 12'b000_11101001010, 11, 1'b0};
        vecs[7] = '{2, 8'h07, 12'b000_10000001110, 11, 1'b0};
        vecs[8] = '{3, 8'h00, 12'b000_11000000000, 11, 1'b0};
        vecs[9] = '{3, 8'h81, 12'b000_11100000010, 11, 1'b0};

        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00;
            vin[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_tx%0d", i), txo[i], 1'b1);
            check($sformatf("reset_ready%0d", i), rdy[i], 1'b1);
            check($sformatf("reset_busy%0d", i), bsy[i], 1'b0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_frame(vecs[i]);

        // Back-to-back: valid held high, second start 41 cycles after the first.
        f1 = 10'b1010101010;
        f2 = 10'b1000011110;
        @(negedge clk);
        din[0] = 8'h55;
        vin[0] = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (c == 0) din[0] = 8'h0F;
            if (c == 41) vin[0] = 1'b0;
            if (c == 60) din[0] = 8'hAA;
            if (c < 40)       exp = f1[c / DIV];
            else if (c == 40) exp = 1'b1;
            else if (c < 81)  exp = f2[(c - 41) / DIV];
            else              exp = 1'b1;
            check($sformatf("b2b_tx c%0d", c), txo[0], exp);
            if (c == 39) check("b2b_ready_c39", rdy[0], 1'b0);
            if (c == 40) check("b2b_ready_c40", rdy[0], 1'b1);
            if (c == 41) check("b2b_ready_c41", rdy[0], 1'b0);
        end

        // Reset mid-frame aborts the frame and holds the line high.
        @(negedge clk);
        din[0] = 8'h00;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_tx_low", txo[0], 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_tx", txo[0], 1'b1);
            check("rst_ready", rdy[0], 1'b1);
            check("rst_busy", bsy[0], 1'b0);
        end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("post_rst_tx", txo[0], 1'b1);
            check("post_rst_busy", bsy[0], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter side of the UART, the counterpart of the receive-side shift register.
- Accepts a parallel byte over a valid/ready handshake and serialises it onto the line: LSB first, 8N1 by default.
- Start, data, optional parity and stop bits are each held for CLK_DIV clocks.
- Sits between the host-side byte source and the tx pad.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- CLK_DIV, 434, clocks per bit period (>=2); counter width is clog2(CLK_DIV).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  source has a byte.
- tx_ready  output  1  block can accept a byte; high only in IDLE.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, tx=1, tx_ready=1, busy=0, baud counter=0, bit index=0, shift register=0. Reset takes priority over everything, including mid-frame; the line returns high at the next edge and the partial frame is aborted, with no completion.
- Handshake: a transfer occurs on an edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register and parity is computed from it.
  - Next state is START, tx_ready drops at that same edge, tx=0 from that edge.
  - tx_valid without tx_ready is ignored; the source must hold the data.
- States:
  - IDLE: tx=1. Goes to START on handshake.
  - START: tx=0 for CLK_DIV clocks, then DATA.
  - DATA: tx=shift[0] for CLK_DIV clocks per bit, shift right each bit; after DATA_BITS bits go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of data bits, XOR PARITY_ODD; lasts CLK_DIV clocks, then STOP.
  - STOP: tx=1 for STOP_BITS*CLK_DIV clocks, then IDLE.
- Baud counter: counts 0..CLK_DIV-1 and wraps. The bit-advance tick is counter==CLK_DIV-1. The counter is cleared on handshake so every bit lasts exactly CLK_DIV clocks.
- Frame timing: tx low for exactly CLK_DIV cycles starting at the cycle after the handshake edge. Total frame = CLK_DIV*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
- Back-to-back: tx_ready rises on the edge entering IDLE, so the earliest next handshake is that cycle. Minimum handshake-to-handshake period = frame length + 1 cycle; the extra cycle is idle-high line time.
- tx_data changes while busy have no effect on the frame in flight.
- Unused bit-index and counter values are unreachable. Illegal state encodings recover to IDLE with tx=1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE/START/DATA/PARITY/STOP (3-bit);
  - default CLK_DIV and DATA_BITS constants, shared with the receiver.
- One natural sub-module: uart_baud_gen, parameter CLK_DIV.
  - Ports clk, rst, clr, tick.
  - Clr zeroes the count; tick pulses one cycle at CLK_DIV-1.
  - Reused by the receiver at a different divide.

Test Plan:
- Reset: hold rst 3 cycles mid-frame, with the frame started at CLK_DIV=4 -> tx=1, tx_ready=1, busy=0 on the next edge; no further low bits.
- Basic 8N1, CLK_DIV=4, tx_data=0xA5 -> tx = 0, then 1,0,1,0,0,1,0,1, then 1. Each level lasts 4 cycles, 40 cycles total; tx_ready low for exactly 40 cycles.
- Even parity, PARITY_EN=1, CLK_DIV=4, tx_data=0xA5 -> parity bit 0 for 4 cycles. With PARITY_ODD=1 -> parity bit 1. 44-cycle frame.
- Two stop bits, STOP_BITS=2, tx_data=0x00 -> 9 low bit periods (36 cycles) then 8 high cycles, then IDLE.
- Back-to-back: tx_valid held high with 0x55 then 0x0F -> second start bit begins exactly 41 cycles after the first. Second frame bits 1,1,1,1,0,0,0,0; tx_data changes mid-frame are ignored.
- Handshake holdoff: pulse tx_valid while busy -> no acceptance, frame unchanged, tx_ready stays 0 until IDLE.
